// File: rtl/def.sv
// Shared definitions for the HI/LO unit: HILO_OP encodings, FSM states and
// the operand magnitude helper used by the divider.
package def;

  localparam logic [1:0] HILO_MUL = 2'd0;
  localparam logic [1:0] HILO_MAD = 2'd1;
  localparam logic [1:0] HILO_MT  = 2'd2;
  localparam logic [1:0] HILO_DIV = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } hilo_state;

  // Two's-complement negate when neg is set. |0x80000000| stays 0x80000000,
  // which is the correct magnitude once read as unsigned.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, with the sign fix-up applied on the way out.
module hilo_div
  import def::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(DIV_ITER + 1);

  logic [32:0]   rem_q;      // partial remainder
  logic [31:0]   quot_q;     // dividend bits shift out the top, quotient bits shift in
  logic [31:0]   divisor_q;
  logic          neg_quot_q;
  logic          neg_rem_q;
  logic          running_q;
  logic [CW-1:0] count_q;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;

  // After every step the remainder is below the divisor, so its top bit is
  // always zero and is dropped when shifting.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[32];

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    rem_sh = {rem_q[31:0], quot_q[31]};
    ge     = (rem_sh >= {1'b0, divisor_q});
    diff   = rem_sh - {1'b0, divisor_q};
  end

  // Divider datapath registers: capture on start, iterate while running.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      running_q  <= 1'b0;
      count_q    <= '0;
    end else if (abort) begin
      running_q  <= 1'b0;
    end else if (start) begin
      rem_q      <= '0;
      quot_q     <= cond_neg(a, is_signed & a[31]);
      divisor_q  <= cond_neg(b, is_signed & b[31]);
      neg_quot_q <= is_signed & (a[31] ^ b[31]);
      neg_rem_q  <= is_signed & a[31];
      running_q  <= 1'b1;
      count_q    <= '0;
    end else if (running_q) begin
      rem_q   <= ge ? diff : rem_sh;
      quot_q  <= {quot_q[30:0], ge};
      count_q <= count_q + 1'b1;
      if (count_q == CW'(DIV_ITER - 1)) begin
        running_q <= 1'b0;
      end
    end
  end

  // done marks the cycle whose edge performs the final step; results are
  // valid from the following cycle until the next start.
  always_comb begin
    done = running_q && (count_q == CW'(DIV_ITER - 1));
    quot = cond_neg(quot_q, neg_quot_q);
    rem  = cond_neg(rem_q[31:0], neg_rem_q);
  end

endmodule

// File: rtl/hilo_unit.sv
// Execute-stage HI/LO unit: single-cycle mult/mad/mt, multi-cycle divide,
// and the architectural HI and LO registers.
module hilo_unit
  import def::*;
#(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [2:0]  op,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  hilo_state   state_q, state_d;
  logic [31:0] hi_q, lo_q;
  logic        accept;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_quot, div_rem;
  logic [63:0] a_ext, b_ext, prod;

  assign accept    = (state_q == IDLE) && en && !abort;
  assign div_start = accept && (op[1:0] == HILO_DIV);

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both signednesses.
  always_comb begin
    a_ext = {{32{is_signed & a[31]}}, a};
    b_ext = {{32{is_signed & b[31]}}, b};
    prod  = a_ext * b_ext;
  end

  hilo_div #(
    .DIV_ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .abort     (abort),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // in the design samples pre-edge values regardless of block order.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: IDLE -> DIV on accepted divide, DIV -> FIX on the last
  // step, FIX -> IDLE; abort returns to IDLE from any busy state.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (div_start) state_d = DIV;
      DIV:     if (abort) state_d = IDLE;
               else if (div_done) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: busy whenever a divide is in flight.
  always_comb begin
    busy = (state_q != IDLE);
    hi   = hi_q;
    lo   = lo_q;
  end

  // HI/LO registers: written by accepted single-cycle ops or by FIX.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (accept) begin
      unique case (op[1:0])
        HILO_MUL: {hi_q, lo_q} <= prod;
        HILO_MAD: {hi_q, lo_q} <= {hi_q, lo_q} + prod;
        HILO_MT:  if (op[2]) hi_q <= a;
                  else       lo_q <= a;
        default:  ;  // divide: results arrive from FIX
      endcase
    end else if ((state_q == FIX) && !abort) begin
      hi_q <= div_rem;
      lo_q <= div_quot;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table, hand-written
// abort/reset sequences and a randomized stream against a reference model.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;
  logic [31:0] hi, lo;
  logic        busy;

  int total = 0;
  int bad = 0;
  int en_busy_cnt = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  hilo_unit #(.DIV_ITER(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  // Issuing en while busy is a pipeline contract violation; count them.
  always @(posedge clk) if (reset_n && en && busy) en_busy_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] o, input logic s,
                              input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] ehi, input logic [31:0] elo);
    vec_t v;
    v.name = name; v.op = o; v.sgn = s; v.a = va; v.b = vb; v.ehi = ehi; v.elo = elo;
    return v;
  endfunction

  // Reference divide from the arithmetic definition on magnitudes.
  function automatic void ref_div(input logic s, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] q, output logic [31:0] r);
    longint ma, mb, uq, ur;
    logic na, nb;
    na = s && va[31];
    nb = s && vb[31];
    ma = na ? -longint'($signed(va)) : longint'(va);
    mb = nb ? -longint'($signed(vb)) : longint'(vb);
    if (mb == 0) begin
      uq = 64'h0000_0000_FFFF_FFFF;
      ur = ma;
    end else begin
      uq = ma / mb;
      ur = ma % mb;
    end
    if (na ^ nb) uq = -uq;
    if (na) ur = -ur;
    q = uq[31:0];
    r = ur[31:0];
  endfunction

  function automatic longint ref_mul(input logic s, input logic [31:0] va, input logic [31:0] vb);
    longint sa, sb;
    sa = s ? longint'($signed(va)) : longint'(va);
    sb = s ? longint'($signed(vb)) : longint'(vb);
    return sa * sb;
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic s, input logic [31:0] va,
                             input logic [31:0] vb);
    longint p;
    logic [31:0] q, r;
    case (o[1:0])
      2'd0: begin p = ref_mul(s, va, vb); {m_hi, m_lo} = p; end
      2'd1: begin p = ref_mul(s, va, vb) + longint'({m_hi, m_lo}); {m_hi, m_lo} = p; end
      2'd2: if (o[2]) m_hi = va; else m_lo = va;
      default: begin ref_div(s, va, vb, q, r); m_hi = r; m_lo = q; end
    endcase
  endtask

  // Issue one op for one cycle, then count busy cycles (bounded).
  task automatic apply(input logic [2:0] o, input logic s, input logic [31:0] va,
                       input logic [31:0] vb, output int nbusy);
    @(negedge clk);
    op = o; is_signed = s; a = va; b = vb; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb;
    logic [2:0] ro;
    logic rs;
    logic [31:0] ra, rb;

    vecs[0]  = mk("mul_s",      3'd0, 1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    vecs[1]  = mk("mul_u",      3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    vecs[2]  = mk("madu",       3'd1, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[3]  = mk("divu_100_7", 3'd3, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14);
    vecs[4]  = mk("div_m7_2",   3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    vecs[5]  = mk("divu_by0",   3'd3, 1'b0, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    vecs[6]  = mk("div_m5_by0", 3'd3, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001);
    vecs[7]  = mk("div_ovf",    3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    vecs[8]  = mk("mthi",       3'd6, 1'b0, 32'hA5A5_A5A5, 32'd0,         32'hA5A5_A5A5, 32'h8000_0000);
    vecs[9]  = mk("mtlo",       3'd2, 1'b0, 32'h5A5A_5A5A, 32'd0,         32'hA5A5_A5A5, 32'h5A5A_5A5A);
    vecs[10] = mk("mad_s",      3'd1, 1'b1, 32'd2,         32'hFFFF_FFFD, 32'hA5A5_A5A5, 32'h5A5A_5A54);

    // Reset with abort and en active: reset must win.
    reset_n = 1'b0; abort = 1'b1; en = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; abort = 1'b0; en = 1'b0;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, nb);
      model_apply(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy_cycles"}, nb, (vecs[i].op[1:0] == 2'd3) ? 32'd33 : 32'd0);
      check({vecs[i].name, "_hi"}, hi, vecs[i].ehi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].elo);
    end

    // Abort in IDLE suppresses a simultaneous en.
    @(negedge clk);
    en = 1'b1; op = 3'd0; is_signed = 1'b0; a = 32'd3; b = 32'd3; abort = 1'b1;
    @(negedge clk);
    en = 1'b0; abort = 1'b0;
    check("idle_abort_hi", hi, m_hi);
    check("idle_abort_lo", lo, m_lo);

    // Divide with a stray mthi at cycle 10 and abort at cycle 20.
    apply(3'd6, 1'b0, 32'hA5A5_A5A5, 32'd0, nb);
    apply(3'd2, 1'b0, 32'h5A5A_5A5A, 32'd0, nb);
    m_hi = 32'hA5A5_A5A5; m_lo = 32'h5A5A_5A5A;
    @(negedge clk);
    en = 1'b1; op = 3'd3; is_signed = 1'b0; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    en = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    en = 1'b0;
    check("abort_mid_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_drop", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'hA5A5_A5A5);
    check("abort_lo", lo, 32'h5A5A_5A5A);
    repeat (40) @(negedge clk);
    check("abort_late_hi", hi, 32'hA5A5_A5A5);
    check("abort_late_lo", lo, 32'h5A5A_5A5A);

    // Reset mid-divide, then a fresh divide.
    @(negedge clk);
    en = 1'b1; op = 3'd3; is_signed = 1'b0; a = 32'd77; b = 32'd5;
    @(negedge clk);
    en = 1'b0;
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    m_hi = '0; m_lo = '0;
    apply(3'd3, 1'b0, 32'd9, 32'd3, nb);
    model_apply(3'd3, 1'b0, 32'd9, 32'd3);
    check("div9_3_cycles", nb, 32'd33);
    check("div9_3_hi", hi, 32'd0);
    check("div9_3_lo", lo, 32'd3);

    // Randomized stream against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      apply(ro, rs, ra, rb, nb);
      model_apply(ro, rs, ra, rb);
      check("rand_busy_cycles", nb, (ro[1:0] == 2'd3) ? 32'd33 : 32'd0);
      check("rand_hi", hi, m_hi);
      check("rand_lo", lo, m_lo);
    end

    // Only the deliberate stray mthi may have been issued while busy.
    check("en_while_busy_count", en_busy_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
